// File: rtl/rr_ram_ctrl.sv
// Dual-slot allocate / dual-slot retire circular buffer controller driving an external RAM.
// Optional RR_RAM_CTRL_RETIRE_BYPASS_EN lets same-cycle retires free slots for allocation.
module rr_ram_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ADDR  = 4,
    parameter int unsigned DEPTH = 1 << ADDR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic [1:0]       alloc_req_i,
    input  logic [WIDTH-1:0] alloc_data_0_i,
    input  logic [WIDTH-1:0] alloc_data_1_i,
    output logic [1:0]       alloc_gnt_o,
    output logic [ADDR-1:0]  alloc_tag_0_o,
    output logic [ADDR-1:0]  alloc_tag_1_o,
    input  logic [1:0]       retire_req_i,
    output logic [1:0]       retire_gnt_o,
    output logic [1:0]       retire_vld_o,
    output logic [WIDTH-1:0] retire_data_0_o,
    output logic [WIDTH-1:0] retire_data_1_o,
    input  logic             lkp_en_i,
    input  logic [ADDR-1:0]  lkp_addr_i,
    output logic [WIDTH-1:0] lkp_data_o,
    output logic [ADDR:0]    count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             ram_wr_en_0_o,
    output logic             ram_wr_en_1_o,
    output logic [ADDR-1:0]  ram_addr_in_0_o,
    output logic [ADDR-1:0]  ram_addr_in_1_o,
    output logic [WIDTH-1:0] ram_data_in_0_o,
    output logic [WIDTH-1:0] ram_data_in_1_o,
    output logic [ADDR-1:0]  ram_addr_out_0_o,
    output logic [ADDR-1:0]  ram_addr_out_1_o,
    output logic [ADDR-1:0]  ram_addr_out_2_o,
    output logic             ram_o_en_0_o,
    output logic             ram_o_en_1_o,
    output logic             ram_o_en_2_o,
    input  logic [WIDTH-1:0] ram_data_out_0_i,
    input  logic [WIDTH-1:0] ram_data_out_1_i,
    input  logic [WIDTH-1:0] ram_data_out_2_i
);

    logic [ADDR-1:0] head_q, head_d;
    logic [ADDR-1:0] tail_q, tail_d;
    logic [ADDR:0]   count_q, count_d;
    logic [ADDR+1:0] free;
    logic [1:0]      alloc_cnt, retire_cnt;

    // Pointer advance with wrap modulo DEPTH (also correct for non-power-of-two DEPTH).
    function automatic logic [ADDR-1:0] ptr_add(input logic [ADDR-1:0] p, input logic [1:0] n);
        logic [ADDR+1:0] s;
        s = {2'b00, p} + {{ADDR{1'b0}}, n};
        if (s >= (ADDR+2)'(DEPTH)) s = s - (ADDR+2)'(DEPTH);
        return s[ADDR-1:0];
    endfunction

    always_comb begin
        retire_vld_o    = {count_q >= (ADDR+1)'(2), count_q != '0};
        retire_gnt_o    = '0;
        retire_gnt_o[0] = reset && retire_req_i[0] && retire_vld_o[0] && !flush_i;
        retire_gnt_o[1] = retire_req_i[1] && retire_gnt_o[0] && retire_vld_o[1];
        retire_cnt      = {1'b0, retire_gnt_o[0]} + {1'b0, retire_gnt_o[1]};

`ifdef RR_RAM_CTRL_RETIRE_BYPASS_EN
        free = (ADDR+2)'(DEPTH) - {1'b0, count_q} + {{ADDR{1'b0}}, retire_cnt};
`else
        free = (ADDR+2)'(DEPTH) - {1'b0, count_q};
`endif

        // Grants are gated by reset so nothing is written while the block is held in reset.
        alloc_gnt_o    = '0;
        alloc_gnt_o[0] = reset && alloc_req_i[0] && (free >= (ADDR+2)'(1)) && !flush_i;
        alloc_gnt_o[1] = alloc_req_i[1] && alloc_gnt_o[0] && (free >= (ADDR+2)'(2));
        alloc_cnt      = {1'b0, alloc_gnt_o[0]} + {1'b0, alloc_gnt_o[1]};

        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = ptr_add(head_q, retire_cnt);
            tail_d  = ptr_add(tail_q, alloc_cnt);
            count_d = count_q + (ADDR+1)'(alloc_cnt) - (ADDR+1)'(retire_cnt);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign alloc_tag_0_o    = tail_q;
    assign alloc_tag_1_o    = ptr_add(tail_q, 2'd1);

    assign ram_wr_en_0_o    = alloc_gnt_o[0];
    assign ram_wr_en_1_o    = alloc_gnt_o[1];
    assign ram_addr_in_0_o  = alloc_tag_0_o;
    assign ram_addr_in_1_o  = alloc_tag_1_o;
    assign ram_data_in_0_o  = alloc_data_0_i;
    assign ram_data_in_1_o  = alloc_data_1_i;

    assign ram_addr_out_0_o = head_q;
    assign ram_addr_out_1_o = ptr_add(head_q, 2'd1);
    assign ram_o_en_0_o     = retire_vld_o[0];
    assign ram_o_en_1_o     = retire_vld_o[1];
    assign retire_data_0_o  = ram_data_out_0_i;
    assign retire_data_1_o  = ram_data_out_1_i;

    assign ram_addr_out_2_o = lkp_addr_i;
    assign ram_o_en_2_o     = lkp_en_i;
    assign lkp_data_o       = ram_data_out_2_i;

    assign count_o          = count_q;
    assign full_o           = (count_q == (ADDR+1)'(DEPTH));
    assign empty_o          = (count_q == '0);

endmodule

// File: tb/tb_rr_ram_ctrl.sv
// Directed bench for rr_ram_ctrl with a behavioural 16x8 RAM behind the RAM-side ports.
// Expectations for the same-cycle retire/alloc case follow RR_RAM_CTRL_RETIRE_BYPASS_EN.
module tb_rr_ram_ctrl;

    logic       clk;
    logic       reset;
    logic       flush;
    logic [1:0] alloc_req;
    logic [7:0] alloc_data_0, alloc_data_1;
    logic [1:0] alloc_gnt;
    logic [3:0] alloc_tag_0, alloc_tag_1;
    logic [1:0] retire_req, retire_gnt, retire_vld;
    logic [7:0] retire_data_0, retire_data_1;
    logic       lkp_en;
    logic [3:0] lkp_addr;
    logic [7:0] lkp_data;
    logic [4:0] count;
    logic       full, empty;
    logic       ram_wr_en_0, ram_wr_en_1;
    logic [3:0] ram_addr_in_0, ram_addr_in_1;
    logic [7:0] ram_data_in_0, ram_data_in_1;
    logic [3:0] ram_addr_out_0, ram_addr_out_1, ram_addr_out_2;
    logic       ram_o_en_0, ram_o_en_1, ram_o_en_2;
    logic [7:0] ram_data_out_0, ram_data_out_1, ram_data_out_2;

    logic [7:0] mem [16];
    int errors = 0;
    int checks = 0;

    rr_ram_ctrl #(.WIDTH(8), .ADDR(4), .DEPTH(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .flush_i          (flush),
        .alloc_req_i      (alloc_req),
        .alloc_data_0_i   (alloc_data_0),
        .alloc_data_1_i   (alloc_data_1),
        .alloc_gnt_o      (alloc_gnt),
        .alloc_tag_0_o    (alloc_tag_0),
        .alloc_tag_1_o    (alloc_tag_1),
        .retire_req_i     (retire_req),
        .retire_gnt_o     (retire_gnt),
        .retire_vld_o     (retire_vld),
        .retire_data_0_o  (retire_data_0),
        .retire_data_1_o  (retire_data_1),
        .lkp_en_i         (lkp_en),
        .lkp_addr_i       (lkp_addr),
        .lkp_data_o       (lkp_data),
        .count_o          (count),
        .full_o           (full),
        .empty_o          (empty),
        .ram_wr_en_0_o    (ram_wr_en_0),
        .ram_wr_en_1_o    (ram_wr_en_1),
        .ram_addr_in_0_o  (ram_addr_in_0),
        .ram_addr_in_1_o  (ram_addr_in_1),
        .ram_data_in_0_o  (ram_data_in_0),
        .ram_data_in_1_o  (ram_data_in_1),
        .ram_addr_out_0_o (ram_addr_out_0),
        .ram_addr_out_1_o (ram_addr_out_1),
        .ram_addr_out_2_o (ram_addr_out_2),
        .ram_o_en_0_o     (ram_o_en_0),
        .ram_o_en_1_o     (ram_o_en_1),
        .ram_o_en_2_o     (ram_o_en_2),
        .ram_data_out_0_i (ram_data_out_0),
        .ram_data_out_1_i (ram_data_out_1),
        .ram_data_out_2_i (ram_data_out_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr_en_0) mem[ram_addr_in_0] <= ram_data_in_0;
        if (ram_wr_en_1) mem[ram_addr_in_1] <= ram_data_in_1;
    end
    assign ram_data_out_0 = mem[ram_addr_out_0];
    assign ram_data_out_1 = mem[ram_addr_out_1];
    assign ram_data_out_2 = mem[ram_addr_out_2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int a = 0; a < 16; a++) mem[a] = 8'h00;
        flush = 0; alloc_req = 0; alloc_data_0 = 0; alloc_data_1 = 0;
        retire_req = 0; lkp_en = 0; lkp_addr = 0;
        reset = 1'b1;
        #1 reset = 1'b0;
        alloc_req = 2'b11; retire_req = 2'b11;
        #2;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_alloc_gnt", 32'(alloc_gnt), 0);
        check("rst_retire_gnt", 32'(retire_gnt), 0);
        check("rst_retire_vld", 32'(retire_vld), 0);
        check("rst_wr_en", 32'({ram_wr_en_1, ram_wr_en_0}), 0);
        check("rst_o_en", 32'({ram_o_en_1, ram_o_en_0}), 0);
        alloc_req = 0; retire_req = 0;
        #9 reset = 1'b1;
        tick();

        // Fill: 8 dual allocations with data 0x10..0x1F
        for (int i = 0; i < 8; i++) begin
            alloc_req = 2'b11;
            alloc_data_0 = 8'(8'h10 + 2 * i);
            alloc_data_1 = 8'(8'h11 + 2 * i);
            #1;
            check("fill_gnt", 32'(alloc_gnt), 3);
            check("fill_tag0", 32'(alloc_tag_0), 32'(2 * i));
            check("fill_tag1", 32'(alloc_tag_1), 32'(2 * i + 1));
            check("fill_wr_addr1", 32'(ram_addr_in_1), 32'(2 * i + 1));
            check("fill_wr_data0", 32'(ram_data_in_0), 32'(8'h10 + 2 * i));
            tick();
        end
        alloc_req = 2'b11;
        #1;
        check("full_count", 32'(count), 16);
        check("full_flag", 32'(full), 1);
        check("full_empty", 32'(empty), 0);
        check("full_no_gnt", 32'(alloc_gnt), 0);
        check("full_no_wr", 32'(ram_wr_en_0), 0);
        alloc_req = 0;
        lkp_en = 1; lkp_addr = 4'd5;
        #1;
        check("lkp_data5", 32'(lkp_data), 32'h15);
        check("lkp_o_en", 32'(ram_o_en_2), 1);
        check("lkp_addr_out", 32'(ram_addr_out_2), 5);
        lkp_en = 0;
        tick();

        // Drain: 8 dual retires
        for (int i = 0; i < 8; i++) begin
            retire_req = 2'b11;
            #1;
            check("drain_vld", 32'(retire_vld), 3);
            check("drain_gnt", 32'(retire_gnt), 3);
            check("drain_data0", 32'(retire_data_0), 32'(8'h10 + 2 * i));
            check("drain_data1", 32'(retire_data_1), 32'(8'h11 + 2 * i));
            check("drain_head", 32'(ram_addr_out_0), 32'(2 * i));
            tick();
            if (i == 0) check("drain_head_after1", 32'(ram_addr_out_0), 2);
        end
        retire_req = 0;
        #1;
        check("drained_empty", 32'(empty), 1);
        check("drained_vld", 32'(retire_vld), 0);
        check("drained_count", 32'(count), 0);
        tick();

        // Fill to 15, then dual request gets only one grant and tail wraps
        for (int i = 0; i < 7; i++) begin
            alloc_req = 2'b11;
            alloc_data_0 = 8'(8'hA0 + 2 * i);
            alloc_data_1 = 8'(8'hA1 + 2 * i);
            tick();
        end
        alloc_req = 2'b01; alloc_data_0 = 8'hAE;
        tick();
        alloc_req = 0;
        #1;
        check("c15_count", 32'(count), 15);
        alloc_req = 2'b11; alloc_data_0 = 8'hAF; alloc_data_1 = 8'hEE;
        #1;
        check("c15_gnt", 32'(alloc_gnt), 1);
        check("c15_tag0", 32'(alloc_tag_0), 15);
        check("c15_wr1", 32'(ram_wr_en_1), 0);
        tick();
        alloc_req = 0;
        #1;
        check("wrap_count", 32'(count), 16);
        check("wrap_tail", 32'(alloc_tag_0), 0);

        // Full: single alloc and single retire in the same cycle
        alloc_req = 2'b01; retire_req = 2'b01; alloc_data_0 = 8'hC0;
        #1;
        check("fr_retire_gnt", 32'(retire_gnt), 1);
        check("fr_retire_data", 32'(retire_data_0), 32'hA0);
`ifdef RR_RAM_CTRL_RETIRE_BYPASS_EN
        check("fr_alloc_gnt", 32'(alloc_gnt), 1);
`else
        check("fr_alloc_gnt", 32'(alloc_gnt), 0);
`endif
        tick();
        alloc_req = 0; retire_req = 0;
        #1;
`ifdef RR_RAM_CTRL_RETIRE_BYPASS_EN
        check("fr_count", 32'(count), 16);
`else
        check("fr_count", 32'(count), 15);
`endif

        // Flush, build count 9, simultaneous alloc+retire, then flush with all requests
        flush = 1;
        tick();
        flush = 0;
        for (int i = 0; i < 4; i++) begin
            alloc_req = 2'b11;
            tick();
        end
        alloc_req = 2'b01;
        tick();
        alloc_req = 0;
        #1;
        check("c9_count", 32'(count), 9);
        alloc_req = 2'b01; retire_req = 2'b01;
        #1;
        check("sim_alloc_gnt", 32'(alloc_gnt), 1);
        check("sim_tag0", 32'(alloc_tag_0), 9);
        check("sim_retire_gnt", 32'(retire_gnt), 1);
        tick();
        alloc_req = 0; retire_req = 0;
        #1;
        check("sim_count", 32'(count), 9);
        check("sim_tail", 32'(alloc_tag_0), 10);
        check("sim_head", 32'(ram_addr_out_0), 1);
        flush = 1; alloc_req = 2'b11; retire_req = 2'b11;
        #1;
        check("flush_alloc_gnt", 32'(alloc_gnt), 0);
        check("flush_retire_gnt", 32'(retire_gnt), 0);
        check("flush_wr_en", 32'(ram_wr_en_0), 0);
        tick();
        flush = 0; alloc_req = 0; retire_req = 0;
        #1;
        check("flush_count", 32'(count), 0);
        check("flush_tail", 32'(alloc_tag_0), 0);
        check("flush_head", 32'(ram_addr_out_0), 0);
        check("flush_empty", 32'(empty), 1);
        alloc_req = 2'b10;
        #1;
        check("req10_gnt", 32'(alloc_gnt), 0);
        tick();
        alloc_req = 0;
        check("req10_count", 32'(count), 0);

        // Build count 5, then asynchronous reset pulse between edges
        for (int k = 0; k < 2; k++) begin
            alloc_req = 2'b11;
            alloc_data_0 = 8'(8'h50 + 2 * k);
            alloc_data_1 = 8'(8'h51 + 2 * k);
            tick();
        end
        alloc_req = 2'b01; alloc_data_0 = 8'h54;
        tick();
        alloc_req = 0;
        #1;
        check("c5_count", 32'(count), 5);
        #1 reset = 1'b0;
        #1;
        check("async_count", 32'(count), 0);
        check("async_empty", 32'(empty), 1);
        check("async_vld", 32'(retire_vld), 0);
        reset = 1'b1;
        lkp_en = 1; lkp_addr = 4'd3;
        #1;
        check("lkp_data3", 32'(lkp_data), 32'h53);
        lkp_en = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rr_ram_ctrl.md
RR_RAM_CTRL -- requirements
Module: rr_ram_ctrl

Interface
REQ-001 SHALL have parameters: WIDTH, default 8, entry width; ADDR, default 4, pointer width; DEPTH, default 1<<ADDR, entry count.
REQ-002 SHALL have ports:
  - clk  in  1  clock.
  - reset  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports:
  - flush  in  1  discard all entries.
  - alloc_req  in  2  dispatch slot requests.
  - alloc_data_0/1  in  WIDTH  slot data.
  - alloc_gnt  out  2  slot grants.
  - alloc_tag_0/1  out  ADDR  assigned entry index.
REQ-004 SHALL have ports:
  - retire_req  in  2  retire requests.
  - retire_gnt  out  2  retire grants.
  - retire_vld  out  2  head/head+1 occupied.
  - retire_data_0/1  out  WIDTH  head/head+1 data.
REQ-005 SHALL have ports:
  - lkp_en  in  1  lookup enable.
  - lkp_addr  in  ADDR  lookup index.
  - lkp_data  out  WIDTH  lookup result.
  - count  out  ADDR+1  occupancy.
  - full  out  1  count==DEPTH.
  - empty  out  1  count==0.
REQ-006 SHALL have RAM-side ports:
  - ram_wr_en_0/1  out  1.
  - ram_addr_in_0/1  out  ADDR.
  - ram_data_in_0/1  out  WIDTH.
  - ram_addr_out_0/1/2  out  ADDR.
  - ram_o_en_0/1/2  out  1.
  - ram_data_out_0/1/2  in  WIDTH.

Function
REQ-007 SHALL keep registered tail, head (ADDR bits, natural wrap modulo DEPTH) and count (0..DEPTH).
REQ-008 alloc_gnt[0] SHALL assert combinationally when alloc_req[0] && free>=1 && !flush; free = DEPTH-count.
REQ-009 alloc_gnt[1] SHALL assert when alloc_req[1] && alloc_gnt[0] && free>=2; alloc_req=2'b10 SHALL yield no grant.
REQ-010 alloc_tag_0 SHALL equal tail and alloc_tag_1 SHALL equal tail+1 (mod DEPTH).
REQ-011 ram_wr_en_0/1 SHALL equal alloc_gnt[0]/[1], with ram_addr_in_0/1 = alloc_tag_0/1 and ram_data_in_0/1 = alloc_data_0/1; the RAM write lands on the next clk edge.
REQ-012 retire_vld[0] SHALL be (count>=1) and retire_vld[1] SHALL be (count>=2).
REQ-013 Retire-side read mapping:
  - ram_addr_out_0 = head, ram_addr_out_1 = head+1.
  - ram_o_en_0/1 = retire_vld[0]/[1].
  - retire_data_0/1 = ram_data_out_0/1.
REQ-014 retire_gnt[0] SHALL be retire_req[0] && retire_vld[0] && !flush; retire_gnt[1] SHALL be retire_req[1] && retire_gnt[0] && retire_vld[1].
REQ-015 Each clk edge, without flush:
  - tail += popcount(alloc_gnt).
  - head += popcount(retire_gnt).
  - count += popcount(alloc_gnt) - popcount(retire_gnt).
  - Simultaneous alloc and retire SHALL both take effect.
REQ-016 flush SHALL, on the next edge, set head=tail=0 and count=0; it overrides same-cycle alloc/retire, and all grants SHALL be 0 while flush is high.
REQ-017 ram_addr_out_2 SHALL equal lkp_addr and ram_o_en_2 SHALL equal lkp_en; lkp_data SHALL equal ram_data_out_2, zero-latency pass-through.
REQ-018 An entry written at edge N SHALL be readable on retire/lookup ports from edge N onward; there is no write-to-read bypass within the same cycle.
REQ-019 count SHALL never exceed DEPTH nor underflow below 0 under any input combination.

Reset
REQ-020 While reset is low:
  - head=0, tail=0, count=0.
  - empty=1, full=0.
  - alloc_gnt=0, retire_gnt=0, retire_vld=0.
  - all ram_wr_en=0, ram_o_en_0/1=0.
REQ-021 Reset asserted mid-operation SHALL discard all occupancy immediately, independent of clk.

Configuration
REQ-022 When RR_RAM_CTRL_RETIRE_BYPASS_EN is defined, free SHALL be DEPTH-count+popcount(retire_gnt), so a full buffer can grant allocation in the same cycle as a retire.
REQ-023 When RR_RAM_CTRL_RETIRE_BYPASS_EN is undefined, free SHALL use registered count only.

Verification
REQ-024 After reset, alloc_req=2'b11 for 8 cycles -> grants 2'b11 each cycle, tags 0/1, 2/3 ... 14/15; then full=1, count=16, next alloc_gnt=2'b00.
REQ-025 With count=15, alloc_req=2'b11 -> alloc_gnt=2'b01, tag=15, and tail wraps to 0.
REQ-026 Fill with data 0x10..0x1F, then retire_req=2'b11 -> retire_data 0x10/0x11 and head=2; 8 such cycles -> empty=1, retire_vld=2'b00.
REQ-027 full, then alloc_req=2'b01 with retire_req=2'b01 in the same cycle:
  - with bypass macro -> alloc_gnt=1, count stays 16.
  - without bypass macro -> alloc_gnt=0, count=15.
REQ-028 count=9, flush=1 together with alloc_req=2'b11 and retire_req=2'b11 -> all grants 0; next cycle count=0, head=tail=0.
REQ-029 Reset pulse low asynchronously between edges while count=5 -> count=0 and empty=1 without a clk edge; lkp_addr=3 with lkp_en=1 -> lkp_data equals the RAM entry at 3.
